// File: rtl/scr1_tapc_dr_shadow_reg.sv
// JTAG TAP data register with a runtime-length shift chain and a handshaked shadow (update) register.
// Optional macro SCR1_TAPC_DR_LEN_CHK_EN enables the shifted-bit-count check that guards shadow updates.
module scr1_tapc_dr_shadow_reg #(
  parameter int                    SCR1_WIDTH       = 32,
  parameter logic [SCR1_WIDTH-1:0] SCR1_RESET_VALUE = '0,
  parameter int                    SCR1_LEN_W       = $clog2(SCR1_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rst_n_sync,
  input  logic                  fsm_dr_select,
  input  logic                  fsm_dr_capture,
  input  logic                  fsm_dr_shift,
  input  logic                  fsm_dr_update,
  input  logic [SCR1_LEN_W-1:0] dr_len,
  input  logic                  din_serial,
  input  logic [SCR1_WIDTH-1:0] din_parallel,
  output logic                  dout_serial,
  output logic [SCR1_WIDTH-1:0] dout_parallel,
  output logic                  upd_valid,
  input  logic                  upd_ready,
  output logic                  len_err,
  output logic                  ovr_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPT,
    ST_SHIFT
  } state_t;

  typedef struct packed {
    state_t                  state;
    logic [SCR1_WIDTH-1:0]   shift_reg;
    logic [SCR1_WIDTH-1:0]   shadow;
    logic [SCR1_LEN_W-1:0]   len_q;
`ifdef SCR1_TAPC_DR_LEN_CHK_EN
    logic [SCR1_LEN_W-1:0]   cnt;
`endif
    logic                    upd_valid;
    logic                    len_err;
    logic                    ovr_err;
  } regs_t;

  localparam logic [SCR1_LEN_W-1:0] WIDTH_L = SCR1_LEN_W'(SCR1_WIDTH);

  localparam regs_t REGS_RST = '{
    state:     ST_IDLE,
    shift_reg: SCR1_RESET_VALUE,
    shadow:    SCR1_RESET_VALUE,
    len_q:     WIDTH_L,
`ifdef SCR1_TAPC_DR_LEN_CHK_EN
    cnt:       '0,
`endif
    upd_valid: 1'b0,
    len_err:   1'b0,
    ovr_err:   1'b0
  };

  regs_t                 r;
  regs_t                 n;
  logic [SCR1_WIDTH-1:0] shifted;
  logic [SCR1_WIDTH-1:0] shift_nxt;
  logic [SCR1_WIDTH-1:0] len_mask;
  logic [SCR1_LEN_W-1:0] len_eff;
  logic                  len_ok;
  logic                  overrun;

  // Only the low len_q bits form the live chain; bits above it keep their value.
  always_comb begin
    shifted = r.shift_reg >> 1;
    for (int i = 0; i < SCR1_WIDTH; i++) begin
      len_mask[i] = (i < int'(r.len_q));
      if (i == int'(r.len_q) - 1) begin
        shift_nxt[i] = din_serial;
      end else if (i < int'(r.len_q) - 1) begin
        shift_nxt[i] = shifted[i];
      end else begin
        shift_nxt[i] = r.shift_reg[i];
      end
    end
  end

  assign len_eff = (dr_len == '0 || dr_len > WIDTH_L) ? WIDTH_L : dr_len;
  assign overrun = r.upd_valid && !upd_ready;

`ifdef SCR1_TAPC_DR_LEN_CHK_EN
  assign len_ok = (r.cnt == r.len_q);
`else
  assign len_ok = 1'b1;
`endif

  // NOTE: every field of n is defaulted from r first, so no path through this block infers a latch.
  always_comb begin
    n         = r;
    n.len_err = 1'b0;
    if (r.upd_valid && upd_ready) begin
      n.upd_valid = 1'b0;
    end
    if (fsm_dr_select) begin
      if (fsm_dr_capture) begin
        n.shift_reg = din_parallel;
        n.len_q     = len_eff;
`ifdef SCR1_TAPC_DR_LEN_CHK_EN
        n.cnt       = '0;
`endif
        n.state     = ST_CAPT;
      end else if (fsm_dr_shift) begin
        if (r.state != ST_IDLE) begin
          n.shift_reg = shift_nxt;
`ifdef SCR1_TAPC_DR_LEN_CHK_EN
          if (r.cnt != '1) begin
            n.cnt = r.cnt + 1'b1;
          end
`endif
          n.state     = ST_SHIFT;
        end
      end else if (fsm_dr_update) begin
        if (r.state != ST_IDLE) begin
          n.state = ST_IDLE;
          if (overrun) begin
            n.ovr_err = 1'b1;
          end else if (!len_ok) begin
            n.len_err = 1'b1;
          end else begin
            // A load coincident with consumption keeps upd_valid high for the new data.
            n.shadow    = r.shift_reg & len_mask;
            n.upd_valid = 1'b1;
          end
        end
      end
    end
    if (!rst_n_sync) begin
      n = REGS_RST;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= REGS_RST;
    end else begin
      r <= n;
    end
  end

  assign dout_serial   = r.shift_reg[0];
  assign dout_parallel = r.shadow;
  assign upd_valid     = r.upd_valid;
  assign len_err       = r.len_err;
  assign ovr_err       = r.ovr_err;

endmodule

// File: doc/scr1_tapc_dr_shadow_reg.md
SCR1_TAPC_DR_SHADOW_REG -- requirements
Module: scr1_tapc_dr_shadow_reg

Interface
REQ-001 Parameter SCR1_WIDTH, default 32, maximum chain length in bits; legal range 1..64.
REQ-002 Parameter SCR1_RESET_VALUE, default '0, reset value of the shift and shadow registers, SCR1_WIDTH bits.
REQ-003 Parameter SCR1_LEN_W, default $clog2(SCR1_WIDTH+1), width of the length and count fields.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 rst_n_sync  in  1  synchronous reset, active-low.
REQ-007 fsm_dr_select / fsm_dr_capture / fsm_dr_shift / fsm_dr_update  in  1 each  TAP FSM DR controls.
REQ-008 dr_len  in  SCR1_LEN_W  runtime active chain length.
REQ-009 din_serial  in  1  TDI bit; din_parallel  in  SCR1_WIDTH  capture data.
REQ-010 dout_serial  out  1  TDO bit, equal to shift_reg[0].
REQ-011 dout_parallel  out  SCR1_WIDTH  shadow (update) register contents.
REQ-012 upd_valid  out  1  shadow holds unconsumed data; upd_ready  in  1  consumer accept.
REQ-013 len_err  out  1  one-cycle pulse on a rejected update; ovr_err  out  1  sticky overrun flag.

Function
REQ-014 The FSM shall have states IDLE, CAPT and SHIFT, with IDLE as the reset state.
REQ-015 Control decoding shall apply only while fsm_dr_select=1, with priority capture > shift > update.
REQ-016 On capture (any state): shift_reg<=din_parallel, len_q<=dr_len, cnt<=0, state->CAPT.
- dr_len of 0 or greater than SCR1_WIDTH shall be latched as SCR1_WIDTH.
REQ-017 On shift in CAPT or SHIFT: shift_reg[len_q-1]<=din_serial and shift_reg[i]<=shift_reg[i+1] for i<len_q-1.
- Bits at len_q and above shall hold their values.
- cnt shall increment, saturating at its all-ones value.
- state->SHIFT.
REQ-018 A shift in IDLE shall be ignored.
REQ-019 dr_len changes after capture shall not affect the chain until the next capture.
REQ-020 On update in CAPT or SHIFT, the update shall be accepted when cnt==len_q and no overrun applies.
- On accept: shadow<=shift_reg with bits at len_q and above forced to 0; upd_valid<=1 on the next edge.
REQ-021 On update with cnt!=len_q: the shadow shall be unchanged and len_err shall pulse for 1 cycle.
REQ-022 On update while upd_valid=1 and upd_ready=0: the shadow shall be unchanged and ovr_err shall set and stay set until reset.
REQ-023 Any update (accepted or rejected) shall move the state to IDLE; an update in IDLE shall be ignored.
REQ-024 upd_valid shall clear on the edge after upd_valid&upd_ready.
REQ-025 Update coincident with acceptance: the new data shall load and upd_valid shall remain 1, with no overrun.
REQ-026 fsm_dr_select=0 shall freeze the shift register, cnt and state; the handshake logic shall continue.
REQ-027 With SCR1_WIDTH==1 the shift shall reduce to shift_reg<=din_serial.

Reset
REQ-028 rst_n low shall asynchronously set, and rst_n_sync low on an edge shall synchronously set, the following: shift_reg and shadow = SCR1_RESET_VALUE; upd_valid, len_err, ovr_err, cnt = 0; len_q = SCR1_WIDTH; state = IDLE.
REQ-029 Reset mid-shift or mid-handshake shall discard all pending data without an upd_valid pulse.
REQ-030 Output reset values: dout_serial = SCR1_RESET_VALUE[0]; dout_parallel = SCR1_RESET_VALUE; all flags 0.

Configuration
REQ-031 Macro SCR1_TAPC_DR_LEN_CHK_EN:
- Defined: the cnt/len_q check of REQ-020/021 shall be active.
- Undefined: cnt shall be removed, every update in CAPT/SHIFT without overrun shall load the shadow, and len_err shall be tied 0.
- All other behaviour shall be identical in both builds.

Verification (SCR1_WIDTH=8, macro defined unless noted)
REQ-032 Capture 8'hA5, dr_len=4, shift 4 bits of din_serial=1 -> dout_serial sequence 1,0,1,0; update -> dout_parallel=8'h0F, upd_valid=1 next cycle.
REQ-033 dr_len=8, shift 7 bits, update -> len_err pulses 1 cycle, dout_parallel unchanged, upd_valid stays 0, state IDLE.
REQ-034 upd_valid=1, upd_ready=0, second valid update -> ovr_err=1 sticky, shadow holds the first value; then upd_ready=1 -> upd_valid=0 next cycle.
REQ-035 Update on the same cycle as upd_valid&upd_ready -> shadow takes the new value, upd_valid stays 1, ovr_err stays 0.
REQ-036 rst_n asserted after 3 of 8 shifts -> all registers at reset values immediately, no upd_valid; rst_n_sync gives the same result at the next edge.
REQ-037 Macro undefined: dr_len=8, shift 5 bits, update -> shadow loads, upd_valid=1, len_err=0.
